// File: rtl/posit_regime_pkg.sv
// rtl/posit_regime_pkg.sv - shared types and round-robin helper for the posit regime arbiter
package posit_regime_pkg;

  // Reference geometry for the packed result record (32-bit posits).
  localparam int PKG_WIDTH = 32;
  localparam int PKG_CW    = $clog2(PKG_WIDTH);

  // Upper bound on lanes the round-robin helper can scan.
  localparam int MAX_REQ   = 16;

  typedef struct packed {
    logic                  sign;
    logic                  special;
    logic [PKG_CW-1:0]     count;
    logic signed [PKG_CW:0] k;
    logic [PKG_WIDTH-2:0]  rem;
  } regime_res_t;

  // Returns the first requesting lane at or above ptr (wrapping modulo n),
  // or -1 when no lane in [0, n) requests.
  function automatic int next_rr_grant(input logic [MAX_REQ-1:0] req,
                                       input int ptr,
                                       input int n);
    int g;
    int j;
    g = -1;
    // Scan from the far end so the smallest offset from ptr wins.
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (i < n) begin
        j = ptr + i;
        if (j >= n) j = j - n;
        if (req[j]) g = j;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/posit_regime_counter.sv
// rtl/posit_regime_counter.sv - combinational regime run-length, k and remainder extraction
// Ports:
//   v     : posit magnitude without the sign bit (WIDTH-1 bits)
//   count : run length of bits equal to v's MSB, saturating at WIDTH-1
//   k     : signed regime value
//   rem   : bits after the regime terminator, MSB-aligned, zero-filled
module posit_regime_counter
  import posit_regime_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-2:0]      v,
  output logic [CW-1:0]         count,
  output logic signed [CW:0]    k,
  output logic [WIDTH-2:0]      rem
);

  localparam int M  = WIDTH - 1;
  localparam int LW = $clog2(M);
  localparam int P  = 1 << LW;

  logic              lead;
  logic [M-1:0]      x;
  logic [P-1:0]      xp;
  logic              zf  [LW+1][P];
  logic [LW:0]       cnt [LW+1][P];
  logic signed [CW:0] cs;
  logic [CW:0]       shamt;

  always_comb begin
    lead = v[M-1];
    // Runs of ones become runs of zeros so one leading-zero tree serves both.
    x  = lead ? ~v : v;
    // Pad with ones below so an all-zero x counts exactly M.
    xp = '1;
    xp[P-1 -: M] = x;

    for (int l = 0; l <= LW; l++) begin
      for (int i = 0; i < P; i++) begin
        zf[l][i]  = 1'b0;
        cnt[l][i] = '0;
      end
    end
    for (int i = 0; i < P; i++) begin
      zf[0][i] = ~xp[P-1-i];
    end
    // Pairwise merge: the left (more significant) half's count stands unless
    // it is all zero, in which case its size is added to the right half.
    for (int l = 1; l <= LW; l++) begin
      for (int i = 0; i < (P >> l); i++) begin
        zf[l][i]  = zf[l-1][2*i] & zf[l-1][2*i+1];
        cnt[l][i] = zf[l-1][2*i] ? ((LW+1)'(1 << (l-1)) + cnt[l-1][2*i+1])
                                 : cnt[l-1][2*i];
      end
    end

    count = CW'(cnt[LW][0]);
    cs    = {1'b0, count};
    k     = lead ? (cs - (CW+1)'(1)) : -cs;
    shamt = {1'b0, count} + (CW+1)'(1);
    rem   = (count == CW'(M)) ? '0 : (v << shamt);
  end

endmodule

// File: rtl/posit_regime_arbiter.sv
// rtl/posit_regime_arbiter.sv - round-robin shared regime decoder with 2-stage valid/ready pipeline
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : synchronous clear of both pipeline stages
//   req_valid/req_ready : per-lane request handshake (ready one-hot or zero)
//   req_posit           : lane i operand at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready : result handshake
//   rsp_id, rsp_sign, rsp_special, rsp_count, rsp_k, rsp_rem : decoded result
module posit_regime_arbiter
  import posit_regime_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH),
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*WIDTH-1:0]   req_posit,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic                     rsp_sign,
  output logic                     rsp_special,
  output logic [CW-1:0]            rsp_count,
  output logic signed [CW:0]       rsp_k,
  output logic [WIDTH-2:0]         rsp_rem
);

  logic [IDW-1:0]    ptr;
  int                gnt;
  logic              gnt_found;
  logic [IDW-1:0]    gnt_id;
  logic [WIDTH-1:0]  lane_posit;
  logic              lane_sign;
  logic [WIDTH-2:0]  lane_abs;
  logic              handshake;

  logic              s1_valid;
  logic              s1_advance;
  logic              s1_free;
  logic [IDW-1:0]    s1_id;
  logic              s1_sign;
  logic              s1_special;
  logic [WIDTH-2:0]  s1_v;

  logic [CW-1:0]     c_count;
  logic signed [CW:0] c_k;
  logic [WIDTH-2:0]  c_rem;

  always_comb begin
    gnt        = next_rr_grant(MAX_REQ'(req_valid), int'(ptr), N_REQ);
    gnt_found  = (gnt >= 0);
    gnt_id     = IDW'(gnt);
    lane_posit = req_posit[gnt_id*WIDTH +: WIDTH];
    lane_sign  = lane_posit[WIDTH-1];
    // Low bits of the two's complement depend only on the low bits.
    lane_abs   = lane_sign ? (~lane_posit[WIDTH-2:0] + 1'b1) : lane_posit[WIDTH-2:0];

    s1_advance = s1_valid & (~rsp_valid | rsp_ready);
    s1_free    = ~s1_valid | s1_advance;
    // rst_n gates the handshake so ready reads zero while reset is held.
    handshake  = gnt_found & s1_free & ~flush & rst_n;

    req_ready  = '0;
    if (handshake) req_ready[gnt_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (handshake) begin
      ptr <= (gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_id      <= '0;
      s1_sign    <= 1'b0;
      s1_special <= 1'b0;
      s1_v       <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (handshake) begin
      s1_valid   <= 1'b1;
      s1_id      <= gnt_id;
      s1_sign    <= lane_sign;
      s1_special <= (lane_posit[WIDTH-2:0] == '0);
      s1_v       <= lane_abs;
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  posit_regime_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_counter (
    .v     (s1_v),
    .count (c_count),
    .k     (c_k),
    .rem   (c_rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_sign    <= 1'b0;
      rsp_special <= 1'b0;
      rsp_count   <= '0;
      rsp_k       <= '0;
      rsp_rem     <= '0;
    end else if (flush) begin
      rsp_valid <= 1'b0;
    end else if (s1_advance) begin
      rsp_valid   <= 1'b1;
      rsp_id      <= s1_id;
      rsp_sign    <= s1_sign;
      rsp_special <= s1_special;
      // Zero and NaR have no regime: report a full-length run with k = 0.
      rsp_count   <= s1_special ? CW'(WIDTH - 1) : c_count;
      rsp_k       <= s1_special ? '0 : c_k;
      rsp_rem     <= s1_special ? '0 : c_rem;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_posit_regime_arbiter.sv
// tb/tb_posit_regime_arbiter.sv - directed self-checking bench for posit_regime_arbiter
module tb_posit_regime_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 8;
  localparam int CW    = 3;
  localparam int IDW   = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   flush;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_posit;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic                   rsp_sign;
  logic                   rsp_special;
  logic [CW-1:0]          rsp_count;
  logic signed [CW:0]     rsp_k;
  logic [WIDTH-2:0]       rsp_rem;

  int checks = 0;
  int errors = 0;

  posit_regime_arbiter #(
    .N_REQ (N_REQ),
    .WIDTH (WIDTH),
    .CW    (CW),
    .IDW   (IDW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_posit   (req_posit),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_sign    (rsp_sign),
    .rsp_special (rsp_special),
    .rsp_count   (rsp_count),
    .rsp_k       (rsp_k),
    .rsp_rem     (rsp_rem)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input int id, input int s, input int sp,
                           input int c, input int k, input int rem);
    check_eq({tag, ".valid"},   32'(rsp_valid),   32'd1);
    check_eq({tag, ".id"},      32'(rsp_id),      id);
    check_eq({tag, ".sign"},    32'(rsp_sign),    s);
    check_eq({tag, ".special"}, 32'(rsp_special), sp);
    check_eq({tag, ".count"},   32'(rsp_count),   c);
    check_eq({tag, ".k"},       32'(rsp_k),       k);
    check_eq({tag, ".rem"},     32'(rsp_rem),     rem);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [WIDTH-1:0] val);
    req_posit[i*WIDTH +: WIDTH] = val;
  endtask

  logic [WIDTH-1:0] vals  [4] = '{8'h6A, 8'h0B, 8'h7F, 8'h40};
  int               exp_c [4] = '{2, 3, 7, 1};
  int               exp_k [4] = '{1, -3, 6, 0};
  int               rr_exp[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    int sent;
    int rcv;
    logic hs;

    rst_n     = 1'b0;
    flush     = 1'b0;
    req_valid = '0;
    req_posit = '0;
    rsp_ready = 1'b1;

    // Reset state
    tick;
    tick;
    @(negedge clk);
    check_eq("rst.valid",   32'(rsp_valid),   0);
    check_eq("rst.ready",   32'(req_ready),   0);
    check_eq("rst.id",      32'(rsp_id),      0);
    check_eq("rst.sign",    32'(rsp_sign),    0);
    check_eq("rst.special", 32'(rsp_special), 0);
    check_eq("rst.count",   32'(rsp_count),   0);
    check_eq("rst.k",       32'(rsp_k),       0);
    check_eq("rst.rem",     32'(rsp_rem),     0);
    tick;
    rst_n = 1'b1;

    // 1: lane 0 sends 0x6A, result two cycles later
    tick;
    req_valid = 4'b0001;
    set_lane(0, 8'h6A);
    @(negedge clk);
    check_eq("t1.ready", 32'(req_ready), 32'b0001);
    tick;
    req_valid = '0;
    @(negedge clk);
    check_eq("t1.lat", 32'(rsp_valid), 0);
    tick;
    @(negedge clk);
    check_rsp("t1", 0, 0, 0, 2, 1, 7'b1010000);

    // 2: lane 2 then lane 1, back-to-back in order
    tick;
    req_valid = 4'b0100;
    set_lane(2, 8'h0B);
    @(negedge clk);
    check_eq("t2.ready0", 32'(req_ready), 32'b0100);
    tick;
    req_valid = 4'b0010;
    set_lane(1, 8'h7F);
    @(negedge clk);
    check_eq("t2.ready1", 32'(req_ready), 32'b0010);
    tick;
    req_valid = '0;
    @(negedge clk);
    check_rsp("t2a", 2, 0, 0, 3, -3, 7'b0110000);
    tick;
    @(negedge clk);
    check_rsp("t2b", 1, 0, 0, 7, 6, 0);
    tick;

    // 3: negative operand, then zero and NaR
    tick;
    req_valid = 4'b1000;
    set_lane(3, 8'hE0);
    @(negedge clk);
    check_eq("t3.ready0", 32'(req_ready), 32'b1000);
    tick;
    set_lane(3, 8'h00);
    @(negedge clk);
    check_eq("t3.ready1", 32'(req_ready), 32'b1000);
    tick;
    set_lane(3, 8'h80);
    @(negedge clk);
    check_eq("t3.ready2", 32'(req_ready), 32'b1000);
    check_rsp("t3neg", 3, 1, 0, 1, -1, 0);
    tick;
    req_valid = '0;
    @(negedge clk);
    check_rsp("t3zero", 3, 0, 1, 7, 0, 0);
    tick;
    @(negedge clk);
    check_rsp("t3nar", 3, 1, 1, 7, 0, 0);
    tick;

    // 4: all lanes valid from pointer 0
    for (int i = 0; i < N_REQ; i++) set_lane(i, 8'h6A);
    for (int c = 0; c < 8; c++) begin
      tick;
      req_valid = (c < 6) ? 4'b1111 : 4'b0000;
      @(negedge clk);
      if (c < 6) check_eq($sformatf("t4.grant%0d", c), 32'(req_ready), 32'(1 << rr_exp[c]));
      if (c >= 2) begin
        check_eq($sformatf("t4.valid%0d", c), 32'(rsp_valid), 1);
        check_eq($sformatf("t4.id%0d", c),    32'(rsp_id),    rr_exp[c-2]);
      end
    end
    tick;
    tick;
    tick;
    req_valid = 4'b1111;
    @(negedge clk);
    check_eq("t4.hold", 32'(req_ready), 32'b0100);
    tick;
    req_valid = '0;
    tick;
    tick;

    // 5: stall for 5 cycles from an empty pipeline, then release
    sent = 0;
    rcv  = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      tick;
      rsp_ready = (cyc >= 5);
      req_valid = (sent < 4) ? 4'b0001 : 4'b0000;
      if (sent < 4) set_lane(0, vals[sent]);
      @(negedge clk);
      hs = req_ready[0];
      if (cyc >= 2 && cyc <= 4) begin
        check_eq($sformatf("t5.stall_valid%0d", cyc), 32'(rsp_valid), 1);
        check_eq($sformatf("t5.stall_count%0d", cyc), 32'(rsp_count), exp_c[0]);
        check_eq($sformatf("t5.stall_k%0d", cyc),     32'(rsp_k),     exp_k[0]);
      end
      if (cyc == 4) begin
        check_eq("t5.ready_drop", 32'(req_ready), 0);
        check_eq("t5.accepted",   sent,           2);
      end
      if (rsp_valid && rsp_ready) begin
        if (rcv < 4) begin
          check_eq($sformatf("t5.count%0d", rcv), 32'(rsp_count), exp_c[rcv]);
          check_eq($sformatf("t5.k%0d", rcv),     32'(rsp_k),     exp_k[rcv]);
        end
        rcv++;
      end
      if (hs) sent++;
    end
    check_eq("t5.received", rcv, 4);

    // 6: flush with both stages full and a lane valid
    tick;
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    set_lane(1, 8'h6A);
    tick;
    tick;
    tick;
    @(negedge clk);
    check_eq("t6.full", 32'(req_ready), 0);
    tick;
    flush     = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("t6.flush_ready", 32'(req_ready), 0);
    tick;
    flush     = 1'b0;
    req_valid = '0;
    @(negedge clk);
    check_eq("t6.flush_valid", 32'(rsp_valid), 0);
    tick;
    req_valid = 4'b1111;
    @(negedge clk);
    check_eq("t6.ptr_kept", 32'(req_ready), 32'b0100);
    check_eq("t6.s1_clear", 32'(rsp_valid), 0);
    tick;
    tick;
    @(negedge clk);
    check_eq("t6.stream", 32'(req_ready), 32'b0001);

    // reset pulsed mid-stream
    tick;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6.rst_valid", 32'(rsp_valid), 0);
    check_eq("t6.rst_ready", 32'(req_ready), 0);
    check_eq("t6.rst_id",    32'(rsp_id),    0);
    check_eq("t6.rst_count", 32'(rsp_count), 0);
    check_eq("t6.rst_rem",   32'(rsp_rem),   0);
    tick;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("t6.ptr_zero", 32'(req_ready), 32'b0001);
    tick;
    req_valid = '0;
    @(negedge clk);
    check_eq("t6.no_stale", 32'(rsp_valid), 0);
    tick;
    @(negedge clk);
    check_eq("t6.first_valid", 32'(rsp_valid), 1);
    check_eq("t6.first_id",    32'(rsp_id),    0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
